// File: rtl/load_store_unit.sv
// Load/store unit between a request port and a dual-port data memory with one-cycle read latency.
// Handles byte, half and word accesses; sub-word stores use a read-modify-write sequence.
module load_store_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, LOAD, RMW} state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  state_t                state, state_next;
  logic                  accept, req_err;
  logic [ADDR_WIDTH-1:0] word_addr;

  logic                  r_we, r_unsigned;
  logic [1:0]            r_size, r_off;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [ADDR_WIDTH-1:0] r_waddr;

  logic                  ren_c, wen_c;
  logic                  resp_valid_next, resp_err_next;
  logic [DATA_WIDTH-1:0] resp_rdata_next;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] load_data, lane_mask, merged;
  logic [4:0]            lane_shift;

  assign req_ready = (state == IDLE) && rst_n;
  assign accept    = req_valid && req_ready;
  assign word_addr = req_addr >> 2;

  assign req_err = (req_size == 2'b11)
                || (req_size == SIZE_HALF && req_addr[0])
                || (req_size == SIZE_WORD && req_addr[1:0] != 2'b00)
                || (word_addr >= ADDR_WIDTH'(NUM_WORDS));

  // Lane extraction and merge always work from the registered request copy.
  assign ld_byte    = mem_rdata[8*r_off +: 8];
  assign ld_half    = mem_rdata[16*r_off[1] +: 16];
  assign lane_shift = (r_size == SIZE_BYTE) ? {r_off, 3'b000} : {r_off[1], 4'b0000};
  assign lane_mask  = ((r_size == SIZE_BYTE) ? DATA_WIDTH'(8'hFF) : DATA_WIDTH'(16'hFFFF)) << lane_shift;
  assign merged     = (mem_rdata & ~lane_mask) | ((r_wdata << lane_shift) & lane_mask);

  always_comb begin
    case (r_size)
      SIZE_BYTE: load_data = r_unsigned ? {{(DATA_WIDTH-8){1'b0}}, ld_byte}
                                        : {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
      SIZE_HALF: load_data = r_unsigned ? {{(DATA_WIDTH-16){1'b0}}, ld_half}
                                        : {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
      default:   load_data = mem_rdata;
    endcase
  end

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next      = state;
    ren_c           = 1'b0;
    wen_c           = 1'b0;
    mem_raddr       = r_waddr;
    mem_waddr       = r_waddr;
    mem_wdata       = r_wdata;
    resp_valid_next = 1'b0;
    resp_err_next   = 1'b0;
    resp_rdata_next = '0;
    case (state)
      IDLE: begin
        mem_raddr = word_addr;
        mem_waddr = word_addr;
        mem_wdata = req_wdata;
        if (accept) begin
          if (req_err) begin
            resp_valid_next = 1'b1;
            resp_err_next   = 1'b1;
          end else if (!req_we) begin
            ren_c      = 1'b1;
            state_next = LOAD;
          end else if (req_size == SIZE_WORD) begin
            wen_c           = 1'b1;
            resp_valid_next = 1'b1;
          end else begin
            ren_c      = 1'b1;
            state_next = RMW;
          end
        end
      end
      LOAD: begin
        resp_valid_next = 1'b1;
        resp_rdata_next = load_data;
        state_next      = IDLE;
      end
      RMW: begin
        wen_c           = r_we;
        mem_wdata       = merged;
        resp_valid_next = 1'b1;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Reset gates the enables immediately so a pending RMW write never lands.
  assign mem_ren = ren_c && rst_n;
  assign mem_wen = wen_c && rst_n;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      r_we       <= 1'b0;
      r_size     <= '0;
      r_unsigned <= 1'b0;
      r_off      <= '0;
      r_wdata    <= '0;
      r_waddr    <= '0;
    end else begin
      state      <= state_next;
      resp_valid <= resp_valid_next;
      resp_err   <= resp_err_next;
      resp_rdata <= resp_rdata_next;
      if (accept) begin
        r_we       <= req_we;
        r_size     <= req_size;
        r_unsigned <= req_unsigned;
        r_off      <= req_addr[1:0];
        r_wdata    <= req_wdata;
        r_waddr    <= word_addr;
      end
    end
  end

endmodule
